// File: rtl/button_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_cmd_arbiter_pkg
// Brief    : Shared state encodings, default timing constants and a width
//            helper for the button command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package button_cmd_arbiter_pkg;

  // Arbiter states: idle/scan vs. holding one command on the port
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned C_DEF_TICK_DIV   = 50000;
  localparam int unsigned C_DEF_STABLE_CNT = 4;

  // Bits needed to hold values 0..value-1; never less than one bit
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : button_cmd_arbiter_if
// Brief    : Button inputs, debounced levels and the valid/ready command
//            port bundled for the arbiter (master) and its consumer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface button_cmd_arbiter_if
  import button_cmd_arbiter_pkg::*;
#(
  parameter int unsigned N_BTN = 4
);
  localparam int unsigned IDW = clog2_min1(N_BTN);

  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] btn_level;
  logic             cmd_valid;
  logic [IDW-1:0]   cmd_id;
  logic             cmd_ready;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    input  btn_sync, cmd_ready, clr_ovf,
    output btn_level, cmd_valid, cmd_id, overflow
  );

  modport slave (
    output btn_sync, cmd_ready, clr_ovf,
    input  btn_level, cmd_valid, cmd_id, overflow
  );

endinterface
`default_nettype wire

// File: rtl/button_cmd_arbiter_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cell
// Brief    : Single-button debouncer. The level flips only after STABLE_CNT
//            consecutive sample ticks disagree with it.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cell
  import button_cmd_arbiter_pkg::*;
#(
  parameter int unsigned STABLE_CNT = C_DEF_STABLE_CNT
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  tick,
  input  wire  din,
  output logic level
);
  localparam int unsigned C_CW = clog2_min1(STABLE_CNT);

  logic [C_CW-1:0] r_cnt;
  logic            r_level;

  // Count disagreeing ticks; any agreeing tick restarts the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (tick) begin
      if (din == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CW'(STABLE_CNT - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/button_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : button_cmd_arbiter
// Brief    : Debounces synchronized buttons, turns debounced rising edges
//            into pending commands and round-robin offers them on a single
//            valid/ready port. Flags presses lost to an already-pending one.
// Revision : 1.0 - initial release
// ============================================================================
module button_cmd_arbiter
  import button_cmd_arbiter_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned TICK_DIV   = C_DEF_TICK_DIV,
  parameter int unsigned STABLE_CNT = C_DEF_STABLE_CNT
) (
  input wire                   clk,
  input wire                   rst_n,
  button_cmd_arbiter_if.master bus
);
  localparam int unsigned IDW  = clog2_min1(N_BTN);
  localparam int unsigned C_SW = IDW + 1;
  localparam int unsigned C_PW = clog2_min1(TICK_DIV);

  logic [C_PW-1:0]  r_presc;
  logic             w_tick;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] r_level_d;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] w_clr;
  logic             w_accept;
  logic             r_ovf;
  arb_state_t       r_state, w_state_nxt;
  logic [IDW-1:0]   r_cmd_id, w_cmd_id_nxt;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [C_SW-1:0]  w_sum;

  assign w_tick = (r_presc == C_PW'(TICK_DIV - 1));

  // Free-running sample prescaler shared by all debouncers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_debounce
    debounce_cell #(.STABLE_CNT(STABLE_CNT)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick),
      .din   (bus.btn_sync[gi]),
      .level (w_level[gi])
    );
  end

  // Previous debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_d <= '0;
    else        r_level_d <= w_level;
  end

  assign w_rise   = w_level & ~r_level_d;
  assign w_accept = (r_state == ST_OFFER) && bus.cmd_ready;

  // One-hot clear of the command being accepted this cycle
  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_cmd_id] = 1'b1;
  end

  // Pending set/clear; a rise on a still-pending button is lost and flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (|(w_rise & r_pend & ~w_clr)) r_ovf <= 1'b1;
      else if (bus.clr_ovf)            r_ovf <= 1'b0;
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping mod N_BTN
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_sum = {1'b0, r_rr_ptr} + C_SW'(k);
      if (w_sum >= C_SW'(N_BTN)) w_sum = w_sum - C_SW'(N_BTN);
      if (!w_found && r_pend[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IDW-1:0];
      end
    end
  end

  // Arbiter state, offered id and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cmd_id <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cmd_id <= w_cmd_id_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next state: latch a winner when idle, hold it until accepted
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_id_nxt = r_cmd_id;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_cmd_id_nxt = w_pick;
          w_state_nxt  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.cmd_ready) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_cmd_id == IDW'(N_BTN - 1)) ? '0 : r_cmd_id + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.btn_level = w_level;
  assign bus.cmd_valid = (r_state == ST_OFFER);
  assign bus.cmd_id    = r_cmd_id;
  assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire
